// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the EX/MEM register.
// Define EX_MULT_EN to build the iterative shift-add multiplier that stalls upstream while busy.
module execute_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_halt,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [4:0]           i_rt_addr,
  input  logic [4:0]           i_rd_addr,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic [4:0]           i_ctl_MEM,
  input  logic [1:0]           i_ctl_WB,
  input  logic [1:0]           i_fwd_a_sel,
  input  logic [1:0]           i_fwd_b_sel,
  input  logic [NB_DATA-1:0]   i_fwd_mem_data,
  input  logic [NB_DATA-1:0]   i_fwd_wb_data,
  output logic [NB_DATA-1:0]   o_ALU_result,
  output logic [NB_DATA-1:0]   o_data_to_write,
  output logic [4:0]           o_reg_dest,
  output logic [4:0]           o_ctl_MEM,
  output logic [1:0]           o_ctl_WB,
  output logic                 o_stall
);

  localparam logic [NB_ALU_OP-1:0] OP_ADD  = NB_ALU_OP'(0);
  localparam logic [NB_ALU_OP-1:0] OP_SUB  = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] OP_AND  = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] OP_OR   = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] OP_XOR  = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] OP_NOR  = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] OP_SLT  = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] OP_SLTU = NB_ALU_OP'(7);
  localparam logic [NB_ALU_OP-1:0] OP_SLL  = NB_ALU_OP'(8);
  localparam logic [NB_ALU_OP-1:0] OP_SRL  = NB_ALU_OP'(9);
  localparam logic [NB_ALU_OP-1:0] OP_SRA  = NB_ALU_OP'(10);
  localparam logic [NB_ALU_OP-1:0] OP_SLLV = NB_ALU_OP'(11);
  localparam logic [NB_ALU_OP-1:0] OP_SRLV = NB_ALU_OP'(12);
  localparam logic [NB_ALU_OP-1:0] OP_SRAV = NB_ALU_OP'(13);
  localparam logic [NB_ALU_OP-1:0] OP_LUI  = NB_ALU_OP'(14);
  localparam logic [NB_ALU_OP-1:0] OP_MUL  = NB_ALU_OP'(15);

  // Single-cycle ALU; MUL yields 0 here and is replaced by the multiplier product when built.
  function automatic logic [NB_DATA-1:0] alu_fn(
    input logic [NB_ALU_OP-1:0] op,
    input logic [NB_DATA-1:0]   a,
    input logic [NB_DATA-1:0]   b,
    input logic [4:0]           sh,
    input logic [15:0]          imm16
  );
    logic signed [NB_DATA-1:0] a_s;
    logic signed [NB_DATA-1:0] b_s;
    logic [NB_DATA-1:0]        res;
    a_s = a;
    b_s = b;
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLT:  res = (a_s < b_s) ? NB_DATA'(1) : '0;
      OP_SLTU: res = (a < b) ? NB_DATA'(1) : '0;
      OP_SLL:  res = b << sh;
      OP_SRL:  res = b >> sh;
      OP_SRA:  res = b_s >>> sh;
      OP_SLLV: res = b << a[4:0];
      OP_SRLV: res = b >> a[4:0];
      OP_SRAV: res = b_s >>> a[4:0];
      OP_LUI:  res = NB_DATA'(imm16) << 16;
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [NB_DATA-1:0] fwd_a;
  logic [NB_DATA-1:0] fwd_b;
  logic [NB_DATA-1:0] operand_b;
  logic [NB_DATA-1:0] alu_res;
  logic [4:0]         dest;

  // Forwarding: 01 takes the EX/MEM result, 10 the MEM/WB value, 00/11 the ID/EX register.
  always_comb begin
    case (i_fwd_a_sel)
      2'b01:   fwd_a = i_fwd_mem_data;
      2'b10:   fwd_a = i_fwd_wb_data;
      default: fwd_a = i_rs_data;
    endcase
    case (i_fwd_b_sel)
      2'b01:   fwd_b = i_fwd_mem_data;
      2'b10:   fwd_b = i_fwd_wb_data;
      default: fwd_b = i_rt_data;
    endcase
    operand_b = i_alu_src ? i_imm : fwd_b;
    dest      = i_reg_dst ? i_rd_addr : i_rt_addr;
    alu_res   = alu_fn(i_alu_op, fwd_a, operand_b, i_imm[10:6], i_imm[15:0]);
  end

  logic               mul_stall;
  logic               bubble;
  logic [NB_DATA-1:0] ex_result;

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t         state_q;
  logic [4:0]         cnt_q;
  logic [NB_DATA-1:0] acc_q;
  logic [NB_DATA-1:0] mcand_q;
  logic [NB_DATA-1:0] mplier_q;

  // Operands are captured on entry so forwarding sources may drain during the bubbles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (!i_halt) begin
      case (state_q)
        S_IDLE: begin
          if (i_alu_op == OP_MUL) begin
            state_q  <= S_BUSY;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= fwd_a;
            mplier_q <= operand_b;
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_stall = ((state_q == S_IDLE) && (i_alu_op == OP_MUL)) || (state_q == S_BUSY);
    bubble    = mul_stall;
    ex_result = (state_q == S_DONE) ? acc_q : alu_res;
  end
`else
  always_comb begin
    mul_stall = 1'b0;
    bubble    = 1'b0;
    ex_result = alu_res;
  end
`endif

  assign o_stall = mul_stall;

  logic [NB_DATA-1:0] alu_result_d, alu_result_q;
  logic [NB_DATA-1:0] data_to_write_d, data_to_write_q;
  logic [4:0]         reg_dest_d, reg_dest_q;
  logic [4:0]         ctl_mem_d, ctl_mem_q;
  logic [1:0]         ctl_wb_d, ctl_wb_q;

  // EX/MEM register: halt holds everything, a stall cycle inserts a bubble in the controls.
  always_comb begin
    alu_result_d    = alu_result_q;
    data_to_write_d = data_to_write_q;
    reg_dest_d      = reg_dest_q;
    ctl_mem_d       = ctl_mem_q;
    ctl_wb_d        = ctl_wb_q;
    if (!i_halt) begin
      alu_result_d    = ex_result;
      data_to_write_d = fwd_b;
      reg_dest_d      = dest;
      ctl_mem_d       = bubble ? 5'd0 : i_ctl_MEM;
      ctl_wb_d        = bubble ? 2'd0 : i_ctl_WB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_result_q    <= '0;
      data_to_write_q <= '0;
      reg_dest_q      <= '0;
      ctl_mem_q       <= '0;
      ctl_wb_q        <= '0;
    end else begin
      alu_result_q    <= alu_result_d;
      data_to_write_q <= data_to_write_d;
      reg_dest_q      <= reg_dest_d;
      ctl_mem_q       <= ctl_mem_d;
      ctl_wb_q        <= ctl_wb_d;
    end
  end

  assign o_ALU_result    = alu_result_q;
  assign o_data_to_write = data_to_write_q;
  assign o_reg_dest      = reg_dest_q;
  assign o_ctl_MEM       = ctl_mem_q;
  assign o_ctl_WB        = ctl_wb_q;

endmodule
